// File: rtl/ram16_ctrl_pkg.sv
// Shared state encoding and widths for the RAM16 capture sequencer.
package ram16_ctrl_pkg;
  localparam int DATA_W     = 16;
  localparam int DROP_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_READ    = 3'd3,
    ST_LATCH   = 3'd4,
    ST_PRESENT = 3'd5
  } ctrl_state_e;
endpackage

// File: rtl/ram16_capture_ctrl.sv
// Capture/drain sequencer for the RAM16 sample buffer (RAM lives in the parent).
// Optional drop counter output enabled by defining RAM16_CAPTURE_DROP_CNT_EN.
module ram16_capture_ctrl
  import ram16_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  arm,
  input  logic                  cont,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic                  ram_clr,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_W-1:0]     ram_di,
  input  logic [DATA_W-1:0]     ram_do,
  input  logic                  ram_full,
  output logic [2:0]            o_dbg_state
`ifdef RAM16_CAPTURE_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  ctrl_state_e           r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_wr_addr, r_rd_addr;
  logic [DATA_W-1:0]     r_out_data;
  logic                  r_out_valid, r_out_last, r_done, r_err;
  logic                  w_wr_fire, w_out_hs;

  // Both streams transfer on a cycle where valid and ready are high together;
  // a producer holding valid keeps its data stable until that cycle.
  assign w_wr_fire = (r_state == ST_CAPTURE) && in_valid;
  assign w_out_hs  = (r_state == ST_PRESENT) && r_out_valid && out_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (arm) w_next = ST_CLEAR;
      ST_CLEAR:   w_next = ST_CAPTURE;
      ST_CAPTURE: if (w_wr_fire && (r_wr_addr == LAST_ADDR)) w_next = ST_READ;
      ST_READ:    w_next = ST_LATCH;
      ST_LATCH:   w_next = ST_PRESENT;
      ST_PRESENT: begin
        if (w_out_hs) begin
          if (r_rd_addr == LAST_ADDR) w_next = cont ? ST_CLEAR : ST_IDLE;
          else                        w_next = ST_READ;
        end
      end
      default:    w_next = ST_IDLE;
    endcase
  end

  // RAM controls are pure decodes of state so they read zero outside their phase.
  always_comb begin
    in_ready = 1'b0;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_clr  = 1'b0;
    ram_addr = '0;
    ram_di   = '0;
    case (r_state)
      ST_CLEAR:   ram_clr = 1'b1;
      ST_CAPTURE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ram_en   = 1'b1;
          ram_we   = 1'b1;
          ram_addr = r_wr_addr;
          ram_di   = in_data;
        end
      end
      ST_READ: begin
        ram_en   = 1'b1;
        ram_addr = r_rd_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_wr_addr   <= '0;
      r_rd_addr   <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      case (r_state)
        ST_CLEAR: begin
          r_wr_addr <= '0;
          r_rd_addr <= '0;
        end
        ST_CAPTURE: if (w_wr_fire) r_wr_addr <= r_wr_addr + 1'b1;
        // rd_addr is zero only on the first READ of a frame.
        ST_READ:    if ((r_rd_addr == '0) && !ram_full) r_err <= 1'b1;
        ST_LATCH: begin
          r_out_data  <= ram_do;
          r_out_valid <= 1'b1;
          r_out_last  <= (r_rd_addr == LAST_ADDR);
        end
        ST_PRESENT: begin
          if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (r_rd_addr == LAST_ADDR) r_done    <= 1'b1;
            else                        r_rd_addr <= r_rd_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RAM16_CAPTURE_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_drop_cnt <= '0;
    end else if ((w_next == ST_CLEAR) && (r_state != ST_CLEAR)) begin
      r_drop_cnt <= '0;
    end else if (in_valid && !in_ready && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_last    = r_out_last;
  assign done        = r_done;
  assign err         = r_err;
  assign busy        = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ram16_capture_ctrl.sv
// Directed bench for ram16_capture_ctrl with a behavioural RAM16 alongside it.
module tb_ram16_capture_ctrl;
  import ram16_ctrl_pkg::*;

  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          CLK, RST, arm, cont, in_valid, in_ready;
  logic [15:0]   in_data, out_data, ram_di, ram_do;
  logic          out_valid, out_last, out_ready, busy, done, err;
  logic          ram_en, ram_we, ram_clr, ram_full, kill_full;
  logic [AW-1:0] ram_addr;
  logic [2:0]    dbg_state;
`ifdef RAM16_CAPTURE_DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  ram16_capture_ctrl #(.ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST(RST), .arm(arm), .cont(cont),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_clr(ram_clr), .ram_addr(ram_addr),
    .ram_di(ram_di), .ram_do(ram_do), .ram_full(ram_full),
    .o_dbg_state(dbg_state)
`ifdef RAM16_CAPTURE_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- RAM16 model ----------------
  logic [15:0]      mem [DEPTH];
  logic [DEPTH-1:0] vbits;

  always @(posedge CLK) begin
    if (RST || ram_clr) begin
      vbits <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      if (RST) ram_do <= '0;
    end else if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr]   <= ram_di;
        vbits[ram_addr] <= 1'b1;
      end else begin
        ram_do <= mem[ram_addr];
      end
    end
  end
  assign ram_full = (&vbits) && !kill_full;

  // ---------------- checker ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [16:0] exp_q[$];
  int n_done = 0, n_clr = 0, n_wr = 0, n_hold = 0;

  initial begin
    logic        prev_valid, prev_ready, prev_last_hs;
    logic [15:0] prev_data;
    logic [16:0] e;
    prev_valid = 0; prev_ready = 0; prev_last_hs = 0; prev_data = 0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        prev_valid = 0; prev_ready = 0; prev_last_hs = 0;
      end else begin
        if (prev_valid && !prev_ready) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, prev_data);
          n_hold++;
        end
        if (done || prev_last_hs) check("done_pulse", done, prev_last_hs);
        if (done) n_done++;
        if (ram_clr) n_clr++;
        if (ram_en && ram_we) n_wr++;
        prev_last_hs = 0;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_word", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e[15:0]);
            check("out_last", out_last, e[16]);
            prev_last_hs = e[16];
          end
        end
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_data  = out_data;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int cycles);
    @(posedge CLK); #1;
    RST = 1;
    repeat (cycles) @(posedge CLK);
    #1;
    RST = 0;
    exp_q.delete();
  endtask

  task automatic check_idle(input string tag);
    @(negedge CLK);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_ram_ctl"}, {ram_en, ram_we, ram_clr}, 0);
    check({tag, "_ram_addr"}, ram_addr, 0);
    check({tag, "_ram_di"}, ram_di, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
    @(posedge CLK); #1;
  endtask

  task automatic run_frame(input logic [15:0] base, input bit do_arm, input bit gaps,
                           input bit bp, input bit cont_v, input bit arm_drain, input bit exp_err);
    int acc, k, hold, budget, d0, w0, h0, c0;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({(i == DEPTH - 1), base + 16'(i)});
    d0 = n_done; w0 = n_wr; h0 = n_hold;
    if (do_arm) begin
      arm = 1;
      @(posedge CLK); #1;
      arm = 0;
      check("clear_state", dbg_state, ST_CLEAR);
      check("clear_pulse", ram_clr, 1);
    end
    acc = 0; k = 0; budget = 0;
    while (acc < DEPTH && budget < 200) begin
      in_valid = gaps ? (k % 2 == 0) : 1'b1;
      in_data  = base + 16'(acc);
      k++; budget++;
      @(negedge CLK);
      if (in_valid && in_ready) begin
        check("wr_addr", ram_addr, acc);
        check("wr_data", ram_di, in_data);
        acc++;
      end else if (in_ready) begin
        check("gap_no_write", ram_en, 0);
      end
      @(posedge CLK); #1;
    end
    in_valid = 0;
    check("accepted", acc, DEPTH);
    check("read_entry", dbg_state, ST_READ);
    check("n_writes", n_wr - w0, DEPTH);

    c0 = n_clr; hold = 0; budget = 0;
    cont = cont_v; arm = arm_drain;
    while (budget < 400) begin
      out_ready = !(bp && out_valid && (out_data == base + 16'd7) && (hold < 5));
      if (!out_ready) hold++;
      @(negedge CLK);
      if (done) break;
      @(posedge CLK); #1;
      budget++;
    end
    #1;
    arm = 0;
    check("done_timeout", (budget < 400), 1);
    check("done_count", n_done - d0, 1);
    check("words_left", exp_q.size(), 0);
    check("hold_cycles", n_hold - h0, bp ? 5 : 0);
    check("clr_in_drain", n_clr - c0, cont_v ? 1 : 0);
    check("err", err, exp_err);
    if (cont_v) begin
      check("rearm_state", dbg_state, ST_CLEAR);
      check("rearm_clr", ram_clr, 1);
    end else begin
      check("end_state", dbg_state, ST_IDLE);
      check("end_busy", busy, 0);
    end
    @(posedge CLK); #1;
    out_ready = 1;
    check("done_one_cycle", done, 0);
    check("post_clr", ram_clr, 0);
    check("post_in_ready", in_ready, cont_v);
    cont = 0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    RST = 1; arm = 0; cont = 0; in_valid = 0; in_data = 0; out_ready = 1; kill_full = 0;
    repeat (3) @(posedge CLK);
    #1;
    check_idle("por");
    RST = 0;
    check_idle("idle");

    run_frame(16'h1000, 1, 0, 0, 0, 0, 0);
    run_frame(16'h2000, 1, 0, 1, 0, 0, 0);
    run_frame(16'h3000, 1, 1, 0, 0, 0, 0);
    run_frame(16'h4000, 1, 0, 0, 1, 1, 0);
    run_frame(16'h5000, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a capture, then a fresh frame.
    arm = 1;
    @(posedge CLK); #1;
    arm = 0;
    k = 0;
    in_valid = 1;
    repeat (10) begin
      in_data = 16'h6000 + 16'(k); k++;
      @(posedge CLK); #1;
    end
    check("mid_capture", dbg_state, ST_CAPTURE);
    in_valid = 0;
    do_reset(2);
    check_idle("mid_rst");
    run_frame(16'h7000, 1, 0, 0, 0, 0, 0);

    // Missing FULL flag raises a sticky error without stopping the drain.
    kill_full = 1;
    run_frame(16'h8000, 1, 0, 0, 0, 0, 1);
    kill_full = 0;
    check("err_sticky", err, 1);
    do_reset(1);
    check_idle("err_rst");

`ifdef RAM16_CAPTURE_DROP_CNT_EN
    in_valid = 1;
    repeat (300) @(posedge CLK);
    #1;
    check("drop_sat", drop_cnt, 255);
    arm = 1;
    @(posedge CLK); #1;
    arm = 0;
    check("drop_clear_state", dbg_state, ST_CLEAR);
    check("drop_clear", drop_cnt, 0);
    in_valid = 0;
    do_reset(1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram16_capture_ctrl.md
Name: ram16_capture_ctrl

Overview:
- Sequencer that owns the RAM16 sample buffer.
- Arms on request, clears the buffer, then fills it with a 16-bit sample stream (valid/ready).
- When the buffer holds DEPTH words, it drains them in address order to a downstream consumer (valid/ready), then idles or re-arms.
- Sits between the spike-detector sample path and the readout/SPI serializer. RAM16 is instantiated alongside it, not inside it.

Parameters:
- ADDR_WIDTH, 5, RAM address width; must match the RAM16 instance.
- DEPTH, 1<<ADDR_WIDTH, words per capture frame.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- arm  in  1  start a capture frame; sampled only in IDLE
- cont  in  1  1 = re-arm automatically after drain; sampled at end of drain
- in_valid  in  1  input sample valid
- in_data  in  16  input sample
- in_ready  out  1  controller accepts a sample this cycle
- out_valid  out  1  readout word valid
- out_data  out  16  readout word
- out_last  out  1  qualifies the word at address DEPTH-1
- out_ready  in  1  consumer accepts the word
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after the last word handshakes
- err  out  1  sticky: ram_full low on entry to drain
- ram_en, ram_we, ram_clr  out  1 each  RAM controls
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_di  out  16  RAM write data
- ram_do  in  16  RAM read data (registered, 1-cycle latency)
- ram_full  in  1  RAM FULL flag

Behaviour:
- Reset (RST=1 at a CLK edge), any state, mid-frame included:
  - state<=IDLE, wr_addr<=0, rd_addr<=0.
  - out_valid, out_data, out_last, done, err <= 0.
  - RAM controls are decoded from state, so all ram_* outputs read 0 in IDLE.
  - RAM16 shares RST, so buffer contents also clear.
- States: IDLE, CLEAR, CAPTURE, READ, LATCH, PRESENT.
- IDLE:
  - arm=1 -> CLEAR.
  - arm is ignored in every other state.
- CLEAR:
  - ram_clr=1 for exactly one cycle; wr_addr<=0, rd_addr<=0 -> CAPTURE.
- CAPTURE:
  - in_ready=1 (combinational, CAPTURE only).
  - On in_valid: ram_en=ram_we=1, ram_addr=wr_addr, ram_di=in_data, wr_addr<=wr_addr+1.
  - Gaps in in_valid simply stall the state.
  - The accepted write at wr_addr==DEPTH-1 -> READ. The exit is decided by the internal counter, not ram_full.
- Samples outside CAPTURE are dropped; in_ready=0 there.
- READ:
  - ram_en=1, ram_we=0, ram_addr=rd_addr -> LATCH.
  - On the first READ cycle of a frame, if ram_full==0, set err<=1. The flag is sticky until RST and does not halt the sequence.
- LATCH:
  - ram_en=0; out_data<=ram_do, out_valid<=1, out_last<=(rd_addr==DEPTH-1) -> PRESENT.
- PRESENT:
  - out_data, out_valid, out_last are held stable until out_ready.
  - On handshake: out_valid<=0, out_last<=0.
  - If rd_addr==DEPTH-1: done<=1 (one cycle); next state is CLEAR if cont=1, else IDLE.
  - Otherwise rd_addr<=rd_addr+1 -> READ.
- Throughput:
  - Drain: 3 cycles/word with out_ready held high.
  - Capture: 1 word/cycle.
- Address counters are ADDR_WIDTH bits wide and never wrap inside a frame.
- out_data retains its last value while out_valid=0.

Optional Feature:
- Macro: RAM16_CAPTURE_DROP_CNT_EN.
- With it:
  - Extra output drop_cnt [7:0] counts cycles with in_valid=1 and in_ready=0.
  - Saturates at 255.
  - Cleared by RST and on entry to CLEAR.
- Without it: port and logic absent; dropped samples are silent.

Decomposition:
- Package ram16_ctrl_pkg holds:
  - the state enum (6 encodings, 3-bit);
  - the data width constant 16;
  - the drop-counter width 8.
- Single module; no sub-module is warranted.
- The RAM16 instance and its wiring belong to the parent.

Test Plan:
- Reset: assert RST for 2 cycles mid-CAPTURE -> all outputs 0, busy=0, state IDLE; a following arm starts a fresh frame with a CLEAR pulse.
- Capture and drain, out_ready=1, in_valid=1 for 32 cycles, in_data=0x1000+i:
  - out_data sequence is 0x1000..0x101F in order;
  - out_last=1 only on 0x101F;
  - done pulses once;
  - err=0; busy drops.
- Backpressure: hold out_ready=0 for 5 cycles at word 7 -> out_valid=1 and out_data=0x1007 stable throughout; word 8 follows after release.
- Input gaps: in_valid toggling 1/0 -> exactly 32 writes; wr_addr advances only on valid; READ is entered after the 32nd accepted sample.
- cont=1: after the last handshake -> ram_clr pulses for 1 cycle, then in_ready=1; arm asserted during the drain has no effect.
- With RAM16_CAPTURE_DROP_CNT_EN:
  - in_valid held for 300 cycles in IDLE -> drop_cnt=255;
  - arm -> drop_cnt returns to 0 in CLEAR.
